// File: rtl/rv_dec_pkg.sv
// Shared RV32I decode types: opcode constants, format tags, decoded-field bundle
// and skid-buffer states.
package rv_dec_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  // FMT_NONE is zero so a cleared entry reads as "no format".
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_func;
    logic [31:0] imm;
    fmt_e        fmt;
    logic        mext;
    logic        illegal;
  } dec_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/rv_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// master = the environment driving instructions in; slave = the decode stage.
interface rv_decode_stage_if
  import rv_dec_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) ();

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [3:0]      out_alu_func;
  logic [XLEN-1:0] out_imm;
  fmt_e            out_fmt;
  logic            out_mext;
  logic            out_illegal;
  logic [PC_W-1:0] out_pc;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_rs1, out_rs2, out_rd,
           out_alu_func, out_imm, out_fmt, out_mext, out_illegal, out_pc
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_rs1, out_rs2, out_rd,
           out_alu_func, out_imm, out_fmt, out_mext, out_illegal, out_pc
  );

endinterface

// File: rtl/rv_dec_comb.sv
// Combinational RV32I instruction decoder (inst -> dec_t).
// Define DEC_RV32M_EN to accept OP/funct7=0000001 as M-extension; otherwise it is illegal.
module rv_dec_comb
  import rv_dec_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       illegal;
  dec_t       raw;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];

  always_comb begin
    raw        = '0;
    raw.opcode = opcode;
    illegal    = 1'b0;
    case (opcode)
      OPC_OP: begin
        raw.rs1 = inst[19:15];
        raw.rs2 = inst[24:20];
        raw.rd  = inst[11:7];
        raw.fmt = FMT_R;
        if (f7 == F7_MULDIV) begin
`ifdef DEC_RV32M_EN
          raw.mext     = 1'b1;
          raw.alu_func = {1'b0, f3};
`else
          illegal = 1'b1;
`endif
        end else begin
          raw.alu_func = {inst[30], f3};
        end
      end
      OPC_OP_IMM: begin
        raw.rs1      = inst[19:15];
        raw.rd       = inst[11:7];
        raw.fmt      = FMT_I;
        raw.imm      = {{20{inst[31]}}, inst[31:20]};
        // Only the shift-right group uses inst[30] (SRLI vs SRAI).
        raw.alu_func = {(f3 == 3'b101) ? inst[30] : 1'b0, f3};
      end
      OPC_LOAD, OPC_JALR: begin
        raw.rs1      = inst[19:15];
        raw.rd       = inst[11:7];
        raw.fmt      = FMT_I;
        raw.imm      = {{20{inst[31]}}, inst[31:20]};
        raw.alu_func = {1'b0, f3};
      end
      OPC_STORE: begin
        raw.rs1      = inst[19:15];
        raw.rs2      = inst[24:20];
        raw.fmt      = FMT_S;
        raw.imm      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        raw.alu_func = {1'b0, f3};
      end
      OPC_BRANCH: begin
        raw.rs1      = inst[19:15];
        raw.rs2      = inst[24:20];
        raw.fmt      = FMT_B;
        raw.imm      = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        raw.alu_func = {1'b0, f3};
      end
      OPC_JAL: begin
        raw.rd  = inst[11:7];
        raw.fmt = FMT_J;
        raw.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        raw.rd  = inst[11:7];
        raw.fmt = FMT_U;
        raw.imm = {inst[31:12], 12'b0};
      end
      default: illegal = 1'b1;
    endcase
    if (inst[1:0] != 2'b11) begin
      illegal = 1'b1;
    end
  end

  // Illegal entries keep only the opcode so downstream sees no stray register reads.
  always_comb begin
    dec = raw;
    if (illegal) begin
      dec         = '0;
      dec.opcode  = opcode;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage with a 2-entry skid buffer and flush.
// Optional M-extension decode is selected by DEC_RV32M_EN (see rv_dec_comb).
module rv_decode_stage
  import rv_dec_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  rv_decode_stage_if.slave  bus
);

  dec_t            in_dec;
  state_e          state_reg;
  dec_t            main_reg;
  dec_t            skid_reg;
  logic [PC_W-1:0] main_pc_reg;
  logic [PC_W-1:0] skid_pc_reg;
  logic            out_valid_reg;
  logic            in_ready_reg;
  logic            in_fire;
  logic            out_fire;
  logic [XLEN-1:0] imm_ext;

  rv_dec_comb u_dec (
    .inst (bus.in_inst),
    .dec  (in_dec)
  );

  assign in_fire  = bus.in_valid & in_ready_reg;
  assign out_fire = out_valid_reg & bus.out_ready;

  // main_reg is always the oldest entry; skid_reg only fills while main is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_EMPTY;
      main_reg      <= '0;
      skid_reg      <= '0;
      main_pc_reg   <= '0;
      skid_pc_reg   <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else if (flush) begin
      state_reg     <= ST_EMPTY;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (in_fire) begin
            main_reg      <= in_dec;
            main_pc_reg   <= bus.in_pc;
            state_reg     <= ST_ONE;
            out_valid_reg <= 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_reg    <= in_dec;
            main_pc_reg <= bus.in_pc;
          end else if (in_fire) begin
            skid_reg     <= in_dec;
            skid_pc_reg  <= bus.in_pc;
            state_reg    <= ST_FULL;
            in_ready_reg <= 1'b0;
          end else if (out_fire) begin
            state_reg     <= ST_EMPTY;
            out_valid_reg <= 1'b0;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_reg     <= skid_reg;
            main_pc_reg  <= skid_pc_reg;
            state_reg    <= ST_ONE;
            in_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= ST_EMPTY;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    imm_ext       = {XLEN{main_reg.imm[31]}};
    imm_ext[31:0] = main_reg.imm;
  end

  assign bus.in_ready     = in_ready_reg;
  assign bus.out_valid    = out_valid_reg;
  assign bus.out_opcode   = main_reg.opcode;
  assign bus.out_rs1      = main_reg.rs1;
  assign bus.out_rs2      = main_reg.rs2;
  assign bus.out_rd       = main_reg.rd;
  assign bus.out_alu_func = main_reg.alu_func;
  assign bus.out_imm      = imm_ext;
  assign bus.out_fmt      = main_reg.fmt;
  assign bus.out_mext     = main_reg.mext;
  assign bus.out_illegal  = main_reg.illegal;
  assign bus.out_pc       = main_pc_reg;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed self-checking bench for rv_decode_stage: decode vectors, back-pressure,
// flush and asynchronous reset. Expectations follow DEC_RV32M_EN when defined.
module tb_rv_decode_stage;
  import rv_dec_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] pc_next = 32'h100;
  logic [31:0] got_pcs[$];
  int valid_seen;
  logic fi;
  logic fo;

  rv_decode_stage_if #(.XLEN(32), .PC_W(32)) bus ();

  rv_decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic dec_case(input string name, input logic [31:0] inst, input logic [6:0] opc,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [3:0] alu, input logic [31:0] imm, input logic [2:0] fmt,
                          input logic mext, input logic ill);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_inst   = inst;
    bus.in_pc     = pc_next;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    $display("[TB] decode %s inst=0x%08h pc=0x%0h", name, inst, pc_next);
    check({name, ".valid"}, bus.out_valid, 1);
    check({name, ".pc"}, bus.out_pc, pc_next);
    check({name, ".opcode"}, bus.out_opcode, opc);
    check({name, ".rd"}, bus.out_rd, rd);
    check({name, ".rs1"}, bus.out_rs1, rs1);
    check({name, ".rs2"}, bus.out_rs2, rs2);
    check({name, ".alu"}, bus.out_alu_func, alu);
    check({name, ".imm"}, bus.out_imm, imm);
    check({name, ".fmt"}, bus.out_fmt, fmt);
    check({name, ".mext"}, bus.out_mext, mext);
    check({name, ".illegal"}, bus.out_illegal, ill);
    pc_next = pc_next + 32'd4;
  endtask

  task automatic idle(input int n);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.in_ready", bus.in_ready, 1);
    check("rst.out_imm", bus.out_imm, 0);
    check("rst.out_pc", bus.out_pc, 0);
    check("rst.out_fmt", bus.out_fmt, 0);
    check("rst.out_illegal", bus.out_illegal, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //        name     inst          opc    rd  rs1 rs2 alu   imm            fmt   m  ill
    dec_case("addi",  32'hFFF00093, 7'h13, 1,  0,  0,  4'h0, 32'hFFFFFFFF, 3'd2, 0, 0);
    dec_case("srai",  32'h40335293, 7'h13, 5,  6,  0,  4'hD, 32'h00000403, 3'd2, 0, 0);
    dec_case("jal",   32'h001000EF, 7'h6F, 1,  0,  0,  4'h0, 32'h00000800, 3'd6, 0, 0);
    dec_case("jal0",  32'h0000006F, 7'h6F, 0,  0,  0,  4'h0, 32'h00000000, 3'd6, 0, 0);
    dec_case("bad07", 32'h00000007, 7'h07, 0,  0,  0,  4'h0, 32'h00000000, 3'd0, 0, 1);
    dec_case("zero",  32'h00000000, 7'h00, 0,  0,  0,  4'h0, 32'h00000000, 3'd0, 0, 1);
    dec_case("sub",   32'h402081B3, 7'h33, 3,  1,  2,  4'h8, 32'h00000000, 3'd1, 0, 0);
    dec_case("sw",    32'hFE20AE23, 7'h23, 0,  1,  2,  4'h2, 32'hFFFFFFFC, 3'd3, 0, 0);
    dec_case("beq",   32'hFE208CE3, 7'h63, 0,  1,  2,  4'h0, 32'hFFFFFFF8, 3'd4, 0, 0);
    dec_case("lui",   32'h123451B7, 7'h37, 3,  0,  0,  4'h0, 32'h12345000, 3'd5, 0, 0);
`ifdef DEC_RV32M_EN
    dec_case("mul",   32'h02208033, 7'h33, 0,  1,  2,  4'h0, 32'h00000000, 3'd1, 1, 0);
`else
    dec_case("mul",   32'h02208033, 7'h33, 0,  0,  0,  4'h0, 32'h00000000, 3'd0, 0, 1);
`endif

    idle(2);
    check("drain.out_valid", bus.out_valid, 0);
    check("drain.in_ready", bus.in_ready, 1);

    // Back-pressure: three PCs streamed into a stalled output.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_inst   = 32'hFFF00093;
    bus.in_pc     = 32'h0;
    @(negedge clk);
    check("bp.ready_one", bus.in_ready, 1);
    check("bp.valid_one", bus.out_valid, 1);
    bus.in_pc = 32'h4;
    @(negedge clk);
    check("bp.ready_full", bus.in_ready, 0);
    check("bp.pc_full", bus.out_pc, 32'h0);
    bus.in_pc = 32'h8;
    @(negedge clk);
    check("bp.ready_hold", bus.in_ready, 0);
    check("bp.pc_hold", bus.out_pc, 32'h0);
    bus.out_ready = 1'b1;
    got_pcs.delete();
    for (int c = 0; c < 10; c++) begin
      fi = bus.in_valid && bus.in_ready;
      fo = bus.out_valid && bus.out_ready;
      if (fo) begin
        got_pcs.push_back(bus.out_pc);
        $display("[TB] drain pc=0x%0h", bus.out_pc);
      end
      @(negedge clk);
      if (fi) bus.in_valid = 1'b0;
    end
    check("bp.count", got_pcs.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < got_pcs.size()) check($sformatf("bp.order%0d", i), got_pcs[i], 32'(4 * i));
    end

    // Flush in FULL with a pending input.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h10;
    @(negedge clk);
    bus.in_pc = 32'h14;
    @(negedge clk);
    check("fl.full", bus.in_ready, 0);
    bus.in_pc = 32'h18;
    flush     = 1'b1;
    @(negedge clk);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("fl.full_valid", bus.out_valid, 0);
    check("fl.full_ready", bus.in_ready, 1);
    // Flush in ONE together with an accepted input.
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h20;
    @(negedge clk);
    bus.in_pc = 32'h24;
    flush     = 1'b1;
    @(negedge clk);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("fl.one_valid", bus.out_valid, 0);
    check("fl.one_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    valid_seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.out_valid) valid_seen++;
      @(negedge clk);
    end
    check("fl.no_ghost", valid_seen, 0);

    // Asynchronous reset while FULL.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_inst   = 32'h123451B7;
    bus.in_pc     = 32'h30;
    @(negedge clk);
    bus.in_pc = 32'h34;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("ar.pre_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar.out_valid", bus.out_valid, 0);
    check("ar.in_ready", bus.in_ready, 1);
    check("ar.out_pc", bus.out_pc, 0);
    check("ar.out_imm", bus.out_imm, 0);
    check("ar.out_rd", bus.out_rd, 0);
    check("ar.out_opcode", bus.out_opcode, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ar.post_valid", bus.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
